// File: rtl/ofdm_pkg.sv
// Shared constants and FSM state encoding for the OFDM DATA-field receive path.
package ofdm_pkg;

  localparam int LEN_WIDTH_DEF = 12;
  localparam int SEED_BITS     = 7;
  localparam int SERVICE_BITS  = 16;
  localparam int RSVD_BITS     = SERVICE_BITS - SEED_BITS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_SERVICE,
    ST_PSDU,
    ST_FLUSH
  } state_e;

endpackage

// File: rtl/psdu_descramble_ctrl_descramble.sv
// 802.11 x^7+x^4+1 frame-synchronous descrambler; the first 7 strobed bits load
// the scrambler state, every later strobed bit is descrambled one cycle later.
module psdu_descramble_ctrl_descramble
  import ofdm_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic in_bit,
  input  logic input_strobe,
  output logic out_bit,
  output logic output_strobe
);

  logic [SEED_BITS-1:0] lfsr;
  logic [2:0]           seed_cnt;
  logic                 seq_bit;

  // lfsr[0] is the newest sequence bit, so taps 7 and 4 sit at [6] and [3].
  assign seq_bit = lfsr[6] ^ lfsr[3];

  // NOTE: this block's reset is synchronous so the controller can re-seed it
  // with a one-cycle pulse on start without touching the global async reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr          <= '0;
      seed_cnt      <= '0;
      out_bit       <= 1'b0;
      output_strobe <= 1'b0;
    end else if (enable) begin
      output_strobe <= 1'b0;
      if (input_strobe) begin
        if (seed_cnt != 3'(SEED_BITS)) begin
          lfsr     <= {lfsr[SEED_BITS-2:0], in_bit};
          seed_cnt <= seed_cnt + 3'd1;
        end else begin
          lfsr          <= {lfsr[SEED_BITS-2:0], seq_bit};
          out_bit       <= in_bit ^ seq_bit;
          output_strobe <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/psdu_descramble_ctrl.sv
// Sequences descrambling of one DATA field: seed, reserved SERVICE bits, then
// packs LENGTH PSDU bytes LSB-first and discards tail/pad bits.
module psdu_descramble_ctrl
  import ofdm_pkg::*;
#(
  parameter int LEN_WIDTH = LEN_WIDTH_DEF
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] length,
  input  logic                 in_bit,
  input  logic                 input_strobe,
  output logic [7:0]           byte_out,
  output logic                 byte_strobe,
  output logic [LEN_WIDTH-1:0] byte_count,
  output logic                 busy,
  output logic                 done,
  output logic                 service_err,
  output logic                 len_err
);

  state_e               state;
  logic [LEN_WIDTH-1:0] len_q;
  logic [3:0]           bit_cnt;
  logic [2:0]           bit_in_byte;
  logic [7:0]           shreg;
  logic                 byte_strobe_q;
  logic                 done_q;

  logic                 start_ok;
  logic                 desc_rst;
  logic                 in_frame;
  logic                 fwd_strobe;
  logic                 ds_bit;
  logic                 ds_strobe;
  logic [7:0]           next_byte;
  logic [LEN_WIDTH-1:0] count_inc;

  assign start_ok   = enable & start & (length != '0);
  assign desc_rst   = ~reset_n | start_ok;
  assign in_frame   = (state == ST_SEED) || (state == ST_SERVICE) || (state == ST_PSDU);
  // The strobe coinciding with start belongs to no packet and is dropped.
  assign fwd_strobe = enable & input_strobe & ~start & in_frame;
  assign next_byte  = {ds_bit, shreg[7:1]};
  assign count_inc  = byte_count + LEN_WIDTH'(1);

  // Pulses are held while disabled and masked here, so a byte completed just
  // before enable drops is presented once enable returns.
  assign byte_strobe = byte_strobe_q & enable;
  assign done        = done_q & enable;

  psdu_descramble_ctrl_descramble u_descramble (
    .clock         (clock),
    .reset         (desc_rst),
    .enable        (enable),
    .in_bit        (in_bit),
    .input_strobe  (fwd_strobe),
    .out_bit       (ds_bit),
    .output_strobe (ds_strobe)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      len_q         <= '0;
      byte_count    <= '0;
      bit_cnt       <= '0;
      bit_in_byte   <= '0;
      shreg         <= '0;
      byte_out      <= '0;
      byte_strobe_q <= 1'b0;
      done_q        <= 1'b0;
      busy          <= 1'b0;
      service_err   <= 1'b0;
      len_err       <= 1'b0;
    end else if (enable) begin
      byte_strobe_q <= 1'b0;
      done_q        <= 1'b0;
      if (start) begin
        // A start in any state aborts the packet in flight, partial byte included.
        bit_cnt     <= '0;
        bit_in_byte <= '0;
        if (length == '0) begin
          len_err <= 1'b1;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end else begin
          len_q       <= length;
          byte_count  <= '0;
          service_err <= 1'b0;
          len_err     <= 1'b0;
          busy        <= 1'b1;
          state       <= ST_SEED;
        end
      end else begin
        case (state)
          ST_IDLE: ;
          ST_SEED: begin
            if (fwd_strobe) begin
              if (bit_cnt == 4'(SEED_BITS - 1)) begin
                bit_cnt <= '0;
                state   <= ST_SERVICE;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          ST_SERVICE: begin
            if (ds_strobe) begin
              if (ds_bit) service_err <= 1'b1;
              if (bit_cnt == 4'(RSVD_BITS - 1)) begin
                bit_cnt <= '0;
                state   <= ST_PSDU;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          ST_PSDU: begin
            if (ds_strobe) begin
              shreg       <= next_byte;
              bit_in_byte <= bit_in_byte + 3'd1;
              if (bit_in_byte == 3'd7) begin
                byte_out      <= next_byte;
                byte_strobe_q <= 1'b1;
                if (byte_count != len_q) byte_count <= count_inc;
                if (count_inc == len_q) begin
                  done_q <= 1'b1;
                  busy   <= 1'b0;
                  state  <= ST_FLUSH;
                end
              end
            end
          end
          ST_FLUSH: state <= ST_IDLE;
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
